// File: rtl/edge_term_pkg.sv
// Shared definitions for the edge termination tile: loopback mode encodings
// and the layout of the mode register loaded from the configuration chain.
package edge_term_pkg;

  localparam int unsigned MODE_W = 6;

  localparam logic [1:0] MODE_STRAIGHT = 2'b00;
  localparam logic [1:0] MODE_ROTATE   = 2'b01;
  localparam logic [1:0] MODE_TIELOW   = 2'b10;
  localparam logic [1:0] MODE_REG      = 2'b11;

  // One 2-bit loopback selector per wire group, LSBs drive the single-hop group.
  typedef struct packed {
    logic [1:0] w4;
    logic [1:0] w2;
    logic [1:0] w1;
  } cfg_mode_t;

endpackage

// File: rtl/clk_buf.sv
// Clock buffer forwarding the user clock up the column.
module clk_buf (
  input  logic a,
  output logic x
);

  assign x = a;

endmodule

// File: rtl/my_buf.sv
// Single-bit fabric buffer used on the unregistered configuration chain.
module my_buf (
  input  logic a,
  output logic x
);

  assign x = a;

endmodule

// File: rtl/term_loop_group.sv
// One wire group of the loopback: straight, rotate, tie-low or one-cycle registered.
module term_loop_group
  import edge_term_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         UserCLK,
  input  logic         Reset,
  input  logic [1:0]   mode,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] in_q;
  logic [W-1:0] rot;

  // Sampled every cycle so entering REG mode never shows stale data.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      in_q <= '0;
    end else begin
      in_q <= in;
    end
  end

  assign rot = {in[0], in[W-1:1]};

  always_comb begin
    out = in;
    case (mode)
      MODE_STRAIGHT: out = in;
      MODE_ROTATE:   out = rot;
      MODE_TIELOW:   out = '0;
      MODE_REG:      out = in_q;
      default:       out = in;
    endcase
  end

endmodule

// File: rtl/edge_term_pipe.sv
// Top-edge termination tile: loops N wires back as S wires under a chain-loaded
// mode register and retimes the frame configuration chain by PIPE_STAGES cycles.
module edge_term_pipe
  import edge_term_pkg::*;
#(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned PIPE_STAGES     = 0,
  parameter int unsigned W1              = 4,
  parameter int unsigned W2              = 8,
  parameter int unsigned W4              = 16,
  parameter int unsigned CFG_FRAME       = 0
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic [W1-1:0]              N1END,
  input  logic [W2-1:0]              N2MID,
  input  logic [W2-1:0]              N2END,
  input  logic [W4-1:0]              N4END,
  output logic [W1-1:0]              S1BEG,
  output logic [W2-1:0]              S2BEG,
  output logic [W2-1:0]              S2BEGb,
  output logic [W4-1:0]              S4BEG,
  output logic                       UserCLKo,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic [MODE_W-1:0]          CfgMode_O
);

  logic      strb_q;
  logic      load;
  cfg_mode_t mode_q;

  clk_buf u_clk_buf (.a(UserCLK), .x(UserCLKo));

  // strb_q resets high so a strobe already asserted at reset release is ignored.
  assign load = FrameStrobe[CFG_FRAME] & ~strb_q;

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      strb_q <= 1'b1;
      mode_q <= '0;
    end else begin
      strb_q <= FrameStrobe[CFG_FRAME];
      if (load) begin
        mode_q <= FrameData[MODE_W-1:0];
      end
    end
  end

  assign CfgMode_O = mode_q;

  term_loop_group #(.W(W1)) u_w1 (
    .UserCLK (UserCLK),
    .Reset   (Reset),
    .mode    (mode_q.w1),
    .in      (N1END),
    .out     (S1BEG)
  );

  term_loop_group #(.W(W2)) u_w2_mid (
    .UserCLK (UserCLK),
    .Reset   (Reset),
    .mode    (mode_q.w2),
    .in      (N2MID),
    .out     (S2BEG)
  );

  term_loop_group #(.W(W2)) u_w2_end (
    .UserCLK (UserCLK),
    .Reset   (Reset),
    .mode    (mode_q.w2),
    .in      (N2END),
    .out     (S2BEGb)
  );

  term_loop_group #(.W(W4)) u_w4 (
    .UserCLK (UserCLK),
    .Reset   (Reset),
    .mode    (mode_q.w4),
    .in      (N4END),
    .out     (S4BEG)
  );

  // Frame chain: data and strobes always travel through the same number of stages.
  if (PIPE_STAGES == 0) begin : g_nopipe
    for (genvar i = 0; i < FrameBitsPerRow; i++) begin : g_data
      my_buf u_buf (.a(FrameData[i]), .x(FrameData_O[i]));
    end
    for (genvar i = 0; i < MaxFramesPerCol; i++) begin : g_strb
      my_buf u_buf (.a(FrameStrobe[i]), .x(FrameStrobe_O[i]));
    end
  end else begin : g_pipe
    logic [FrameBitsPerRow-1:0] data_q [PIPE_STAGES];
    logic [MaxFramesPerCol-1:0] strb_pipe_q [PIPE_STAGES];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      logic [FrameBitsPerRow-1:0] data_d;
      logic [MaxFramesPerCol-1:0] strb_d;

      if (s == 0) begin : g_head
        assign data_d = FrameData;
        assign strb_d = FrameStrobe;
      end else begin : g_tail
        assign data_d = data_q[s-1];
        assign strb_d = strb_pipe_q[s-1];
      end

      always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
          data_q[s]      <= '0;
          strb_pipe_q[s] <= '0;
        end else begin
          data_q[s]      <= data_d;
          strb_pipe_q[s] <= strb_d;
        end
      end
    end

    assign FrameData_O   = data_q[PIPE_STAGES-1];
    assign FrameStrobe_O = strb_pipe_q[PIPE_STAGES-1];
  end

endmodule
